// File: rtl/adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// adder_sum_accumulator
//
// Purpose:
//   Collects BURST_LEN unsigned 17-bit sums from the upstream 16-bit adder stage
//   into an ACC_W-bit accumulator. When the burst is complete, the result is
//   presented on a valid/ready output handshake. The block has two states:
//     ACCUM - taking sums (sum_ready=1)
//     HOLD  - presenting the result (sum_ready=0)
//   A carry out of bit ACC_W-1 on any add sets a sticky overflow flag for the
//   burst. clear aborts the current burst from either state. clear has priority
//   over both the input accept and the output handshake.
//
// Parameters:
//   BURST_LEN  number of sums per result (1..255)
//   ACC_W      accumulator / result width (17..32)
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous reset, active low
//   sum_in     17-bit unsigned sum
//   sum_valid  sum_in holds a valid sum
//   sum_ready  block accepts sum_in this cycle
//   clear      synchronous abort of the current burst
//   acc_out    accumulated burst total
//   acc_ovf    burst total exceeded 2^ACC_W-1 (qualified by acc_valid)
//   acc_valid  acc_out / acc_ovf hold a completed burst result
//   acc_ready  consumer takes the result this cycle
//
// Build option:
//   SUM_SATURATE_EN  when defined, the accumulator clamps at all-ones after the
//                    first overflowing add of a burst. When undefined, the
//                    accumulator wraps modulo 2^ACC_W. acc_ovf is the same in
//                    both builds.
// -----------------------------------------------------------------------------
module adder_sum_accumulator #(
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned ACC_W     = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [16:0]      sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  // The counter must reach BURST_LEN itself, so it needs one extra code.
  localparam int unsigned      CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BURST_LEN);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Add with one spare bit on top. That top bit is the carry past bit ACC_W-1.
  function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] acc,
                                              input logic [16:0]      s);
    add_wide = {1'b0, acc} + {{(ACC_W - 16){1'b0}}, s};
  endfunction

  state_e             state_q,   state_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               ovf_q,     ovf_d;
  logic [ACC_W-1:0]   out_q,     out_d;
  logic               out_ovf_q, out_ovf_d;
  logic               valid_q,   valid_d;
  logic               rdy_q,     rdy_d;

  logic               accept_s;
  logic [ACC_W:0]     sum_wide_s;
  logic               ovf_next_s;
  logic [ACC_W-1:0]   acc_next_s;

  // sum_ready is registered (it is low until the first edge after reset).
  // It is also gated combinationally by clear, because clear blocks the
  // accept in the same cycle.
  assign sum_ready = rdy_q & ~clear;
  assign accept_s  = sum_valid & sum_ready;

  assign acc_out   = out_q;
  assign acc_ovf   = out_ovf_q;
  assign acc_valid = valid_q;

  // Datapath: accumulator value and sticky overflow that an accept would produce.
  always_comb begin
    sum_wide_s = add_wide(acc_q, sum_in);
    ovf_next_s = ovf_q | sum_wide_s[ACC_W];
`ifdef SUM_SATURATE_EN
    if (ovf_next_s) begin
      acc_next_s = {ACC_W{1'b1}};
    end else begin
      acc_next_s = sum_wide_s[ACC_W-1:0];
    end
`else
    acc_next_s = sum_wide_s[ACC_W-1:0];
`endif
  end

  // Next-state and next-output logic for the ACCUM/HOLD controller.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_d     = out_q;
    out_ovf_d = out_ovf_q;
    valid_d   = valid_q;

    if (clear) begin
      state_d   = ST_ACCUM;
      acc_d     = {ACC_W{1'b0}};
      cnt_d     = {CNT_W{1'b0}};
      ovf_d     = 1'b0;
      out_d     = {ACC_W{1'b0}};
      out_ovf_d = 1'b0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_s) begin
            acc_d = acc_next_s;
            ovf_d = ovf_next_s;
            // Saturating increment: the counter must never wrap past BURST_LEN.
            if (cnt_q == FULL_CNT) begin
              cnt_d = cnt_q;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_q == LAST_CNT) begin
              state_d   = ST_HOLD;
              out_d     = acc_next_s;
              out_ovf_d = ovf_next_s;
              valid_d   = 1'b1;
            end else begin
              state_d   = ST_ACCUM;
            end
          end else begin
            state_d = ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            // The handshake cycle does not accept a sum: sum_ready is low in HOLD.
            state_d   = ST_ACCUM;
            acc_d     = {ACC_W{1'b0}};
            cnt_d     = {CNT_W{1'b0}};
            ovf_d     = 1'b0;
            out_d     = {ACC_W{1'b0}};
            out_ovf_d = 1'b0;
            valid_d   = 1'b0;
          end else begin
            state_d   = ST_HOLD;
          end
        end
        default: begin
          state_d   = ST_ACCUM;
          acc_d     = {ACC_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          ovf_d     = 1'b0;
          out_d     = {ACC_W{1'b0}};
          out_ovf_d = 1'b0;
          valid_d   = 1'b0;
        end
      endcase
    end

    rdy_d = (state_d == ST_ACCUM);
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ACCUM;
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
      out_q     <= {ACC_W{1'b0}};
      out_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_q     <= out_d;
      out_ovf_q <= out_ovf_d;
      valid_q   <= valid_d;
      rdy_q     <= rdy_d;
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_sum_accumulator
//
// Self-checking bench with three instances of adder_sum_accumulator:
//   index 0: BURST_LEN=4 (default)
//   index 1: BURST_LEN=16
//   index 2: BURST_LEN=1
// All three instances use ACC_W=20. Expected results come from a constant table
// and from a reference model. The model sums the burst in wide arithmetic, then
// applies the overflow and saturate/wrap rules.
// -----------------------------------------------------------------------------
module tb_adder_sum_accumulator;

  localparam int          TMO  = 40;
  localparam logic [19:0] MAXV = 20'hFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sv, clr, ar;
  logic [16:0] sin [3];
  wire  [2:0]  sr, ovf, av;
  wire  [19:0] aout [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.BURST_LEN(4), .ACC_W(20)) u_dut4 (
    .clk(clk), .reset(rst_n), .sum_in(sin[0]), .sum_valid(sv[0]), .sum_ready(sr[0]),
    .clear(clr[0]), .acc_out(aout[0]), .acc_ovf(ovf[0]), .acc_valid(av[0]), .acc_ready(ar[0]));

  adder_sum_accumulator #(.BURST_LEN(16), .ACC_W(20)) u_dut16 (
    .clk(clk), .reset(rst_n), .sum_in(sin[1]), .sum_valid(sv[1]), .sum_ready(sr[1]),
    .clear(clr[1]), .acc_out(aout[1]), .acc_ovf(ovf[1]), .acc_valid(av[1]), .acc_ready(ar[1]));

  adder_sum_accumulator #(.BURST_LEN(1), .ACC_W(20)) u_dut1 (
    .clk(clk), .reset(rst_n), .sum_in(sin[2]), .sum_valid(sv[2]), .sum_ready(sr[2]),
    .clear(clr[2]), .acc_out(aout[2]), .acc_ovf(ovf[2]), .acc_valid(av[2]), .acc_ready(ar[2]));

  typedef struct {
    logic [16:0] s0, s1, s2, s3;
    logic [19:0] exp_out;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl [5];

  function automatic int bl(input int d);
    case (d)
      0:       return 4;
      1:       return 16;
      default: return 1;
    endcase
  endfunction

  // Reference model: exact sum first, then the overflow and saturate/wrap rules.
  task automatic model(input logic [16:0] q[$], output logic [19:0] eo, output logic eov);
    longint t;
    t = 0;
    foreach (q[i]) t += longint'(q[i]);
    eov = (t > longint'(MAXV));
`ifdef SUM_SATURATE_EN
    eo = eov ? MAXV : t[19:0];
`else
    eo = t[19:0];
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is at posedge+1. Holds sum_valid until accepted; returns at posedge+1.
  task automatic send(input int d, input logic [16:0] v);
    int n;
    n = 0;
    sin[d] = v;
    sv[d]  = 1'b1;
    @(negedge clk);
    while (sr[d] !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk($sformatf("accept_wait_d%0d", d), {31'd0, sr[d]}, 32'd1);
    @(posedge clk); #1;
    sv[d]  = 1'b0;
    sin[d] = 17'($urandom);
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      sv[d]  = 1'b0;
      sin[d] = 17'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Checks the result. Then holds it for 'hold' cycles with sum_valid high.
  // Then does the acc_ready handshake (still offering a garbage sum) and checks
  // the block is back in ACCUM.
  task automatic get_result(input int d, input logic [19:0] eo, input logic eov,
                            input int hold, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (av[d] !== 1'b1 && n < TMO) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd0);
    chk({tag, "_valid"}, {31'd0, av[d]}, 32'd1);
    chk({tag, "_out"}, {12'd0, aout[d]}, {12'd0, eo});
    chk({tag, "_ovf"}, {31'd0, ovf[d]}, {31'd0, eov});
    chk({tag, "_rdy_in_hold"}, {31'd0, sr[d]}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      sv[d]  = 1'b1;
      sin[d] = 17'($urandom);
      @(negedge clk);
      chk({tag, "_hold_rdy"}, {31'd0, sr[d]}, 32'd0);
      chk({tag, "_hold_valid"}, {31'd0, av[d]}, 32'd1);
      chk({tag, "_hold_out"}, {12'd0, aout[d]}, {12'd0, eo});
      chk({tag, "_hold_ovf"}, {31'd0, ovf[d]}, {31'd0, eov});
    end
    @(posedge clk); #1;
    ar[d]  = 1'b1;
    sv[d]  = 1'b1;
    sin[d] = 17'($urandom);
    @(negedge clk);
    chk({tag, "_hs_valid"}, {31'd0, av[d]}, 32'd1);
    chk({tag, "_hs_rdy"}, {31'd0, sr[d]}, 32'd0);
    @(posedge clk); #1;
    ar[d] = 1'b0;
    sv[d] = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, {31'd0, av[d]}, 32'd0);
    chk({tag, "_post_rdy"}, {31'd0, sr[d]}, 32'd1);
    chk({tag, "_post_ovf"}, {31'd0, ovf[d]}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_burst(input int d, input logic [16:0] q[$], input int hold,
                           input bit gaps, input string tag);
    logic [19:0] eo;
    logic        eov;
    foreach (q[i]) begin
      if (gaps && $urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 2));
      send(d, q[i]);
    end
    model(q, eo, eov);
    get_result(d, eo, eov, hold, tag);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_out_d%0d", tag, d), {12'd0, aout[d]}, 32'd0);
      chk($sformatf("%s_ovf_d%0d", tag, d), {31'd0, ovf[d]}, 32'd0);
      chk($sformatf("%s_valid_d%0d", tag, d), {31'd0, av[d]}, 32'd0);
      chk($sformatf("%s_rdy_d%0d", tag, d), {31'd0, sr[d]}, 32'd0);
    end
  endtask

  // Hard stop in case something hangs.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] q[$];

    tbl[0] = '{s0: 17'd1,       s1: 17'd2,       s2: 17'd3,       s3: 17'd4,       exp_out: 20'd10,      exp_ovf: 1'b0};
    tbl[1] = '{s0: 17'd0,       s1: 17'd0,       s2: 17'd0,       s3: 17'd0,       exp_out: 20'd0,       exp_ovf: 1'b0};
    tbl[2] = '{s0: 17'h1FFFF,   s1: 17'h1FFFF,   s2: 17'h1FFFF,   s3: 17'h1FFFF,   exp_out: 20'h7FFFC,   exp_ovf: 1'b0};
    tbl[3] = '{s0: 17'h10000,   s1: 17'h0FFFF,   s2: 17'd1,       s3: 17'd0,       exp_out: 20'h20000,   exp_ovf: 1'b0};
    tbl[4] = '{s0: 17'd100,     s1: 17'd200,     s2: 17'd300,     s3: 17'd400,     exp_out: 20'd1000,    exp_ovf: 1'b0};

    rst_n = 1'b0;
    sv    = 3'b000;
    clr   = 3'b000;
    ar    = 3'b000;
    for (int d = 0; d < 3; d++) sin[d] = 17'd0;

    // Reset state, and sum_ready stays low until the first edge after release.
    #2;
    chk_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("rdy_before_edge_d%0d", d), {31'd0, sr[d]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("rdy_after_edge_d%0d", d), {31'd0, sr[d]}, 32'd1);
    @(posedge clk); #1;

    // Table vectors on the BURST_LEN=4 instance, with hold lengths 0,2,3,4,5.
    for (int i = 0; i < 5; i++) begin
      send(0, tbl[i].s0);
      send(0, tbl[i].s1);
      send(0, tbl[i].s2);
      send(0, tbl[i].s3);
      get_result(0, tbl[i].exp_out, tbl[i].exp_ovf, (i == 0) ? 0 : i + 1, $sformatf("tbl%0d", i));
    end

    // clear after two accepts, with a sum offered in the same cycle.
    send(0, 17'd11);
    send(0, 17'd22);
    clr[0] = 1'b1; sv[0] = 1'b1; sin[0] = 17'd33;
    @(negedge clk);
    chk("clear_rdy", {31'd0, sr[0]}, 32'd0);
    @(posedge clk); #1;
    clr[0] = 1'b0; sv[0] = 1'b0;
    @(negedge clk);
    chk("clear_valid", {31'd0, av[0]}, 32'd0);
    chk("clear_rdy_after", {31'd0, sr[0]}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(0, 17'd5);
    get_result(0, 20'd20, 1'b0, 1, "clear_then_5s");

    // clear in HOLD, at the same time as acc_ready and a sum.
    for (int i = 0; i < 4; i++) send(0, 17'd9);
    @(negedge clk);
    chk("hold_clr_pre_out", {12'd0, aout[0]}, 32'd36);
    @(posedge clk); #1;
    clr[0] = 1'b1; ar[0] = 1'b1; sv[0] = 1'b1; sin[0] = 17'd77;
    @(negedge clk);
    chk("hold_clr_rdy", {31'd0, sr[0]}, 32'd0);
    @(posedge clk); #1;
    clr[0] = 1'b0; ar[0] = 1'b0; sv[0] = 1'b0;
    @(negedge clk);
    chk("hold_clr_valid", {31'd0, av[0]}, 32'd0);
    chk("hold_clr_out", {12'd0, aout[0]}, 32'd0);
    @(posedge clk); #1;
    q = '{17'd1, 17'd2, 17'd3, 17'd4};
    run_burst(0, q, 0, 1'b0, "after_hold_clr");

    // Sixteen maximum sums overflow a 20-bit accumulator.
    for (int i = 0; i < 16; i++) send(1, 17'h1FFFF);
`ifdef SUM_SATURATE_EN
    get_result(1, 20'hFFFFF, 1'b1, 1, "ovf16");
`else
    get_result(1, 20'hFFFF0, 1'b1, 1, "ovf16");
`endif

    // Reset while in HOLD (an overflowing burst on the 16-sum instance is pending).
    for (int i = 0; i < 16; i++) send(1, 17'h1FFFF);
    @(negedge clk);
    chk("rst_hold_pre_valid", {31'd0, av[1]}, 32'd1);
    chk("rst_hold_pre_ovf", {31'd0, ovf[1]}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_hold");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    q = '{17'd7, 17'd0, 17'd0, 17'd1};
    run_burst(0, q, 0, 1'b0, "rst_hold_7001");
    q.delete();
    for (int k = 0; k < 16; k++) q.push_back(17'd3);
    run_burst(1, q, 0, 1'b0, "rst_hold_16x3");

    // Reset mid-burst.
    send(0, 17'd50);
    send(0, 17'd60);
    sv[0] = 1'b1; sin[0] = 17'd70;
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk); #3;
    rst_n = 1'b1;
    sv[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdy_before_edge", {31'd0, sr[0]}, 32'd0);
    @(posedge clk); #1;
    q = '{17'd7, 17'd0, 17'd0, 17'd1};
    run_burst(0, q, 0, 1'b0, "rst_mid_7001");

    // BURST_LEN=1 with acc_ready tied high.
    ar[2] = 1'b1;
    send(2, 17'd3);
    @(negedge clk);
    chk("bl1_r1_valid", {31'd0, av[2]}, 32'd1);
    chk("bl1_r1_out", {12'd0, aout[2]}, 32'd3);
    chk("bl1_r1_rdy_low", {31'd0, sr[2]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bl1_r1_valid_drop", {31'd0, av[2]}, 32'd0);
    chk("bl1_r1_rdy_back", {31'd0, sr[2]}, 32'd1);
    @(posedge clk); #1;
    send(2, 17'd9);
    @(negedge clk);
    chk("bl1_r2_valid", {31'd0, av[2]}, 32'd1);
    chk("bl1_r2_out", {12'd0, aout[2]}, 32'd9);
    chk("bl1_r2_rdy_low", {31'd0, sr[2]}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bl1_r2_valid_drop", {31'd0, av[2]}, 32'd0);
    chk("bl1_r2_rdy_back", {31'd0, sr[2]}, 32'd1);
    @(posedge clk); #1;
    ar[2] = 1'b0;

    // Randomized bursts compared against the reference model.
    for (int b = 0; b < 20; b++) begin
      q.delete();
      for (int k = 0; k < bl(0); k++) q.push_back(17'($urandom));
      run_burst(0, q, $urandom_range(0, 3), 1'b1, $sformatf("rnd4_%0d", b));
    end
    for (int b = 0; b < 6; b++) begin
      q.delete();
      for (int k = 0; k < bl(1); k++) q.push_back(17'($urandom));
      run_burst(1, q, $urandom_range(0, 2), 1'b1, $sformatf("rnd16_%0d", b));
    end
    for (int b = 0; b < 10; b++) begin
      q.delete();
      q.push_back(17'($urandom));
      run_burst(2, q, $urandom_range(0, 2), 1'b1, $sformatf("rnd1_%0d", b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
ADDER_SUM_ACCUMULATOR -- requirements
Module: adder_sum_accumulator

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, number of sums accumulated per result (legal range 1..255).
REQ-002 SHALL have parameter ACC_W, default 20, accumulator/result width in bits (legal range 17..32).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sum_in  input  17  unsigned sum from the 16-bit adder stage.
REQ-006 SHALL have port sum_valid  input  1  sum_in holds a valid sum.
REQ-007 SHALL have port sum_ready  output  1  block accepts sum_in this cycle.
REQ-008 SHALL have port clear  input  1  synchronous abort of the current burst.
REQ-009 SHALL have port acc_out  output  ACC_W  accumulated burst total.
REQ-010 SHALL have port acc_ovf  output  1  burst exceeded 2^ACC_W-1; qualified by acc_valid.
REQ-011 SHALL have port acc_valid  output  1  acc_out/acc_ovf hold a completed burst result.
REQ-012 SHALL have port acc_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 SHALL implement two states: ACCUM (collecting sums) and HOLD (presenting result).
REQ-014 SHALL drive sum_ready=1 in ACCUM and sum_ready=0 in HOLD or while clear=1.
REQ-015 SHALL accept a sum only on a cycle with sum_valid=1 and sum_ready=1; each accept adds zero-extended sum_in to the accumulator and increments the sample counter.
REQ-016 SHALL set acc_ovf (sticky for the burst) when any add carries past bit ACC_W-1.
REQ-017 SHALL, on the BURST_LEN-th accept, enter HOLD on the next edge with acc_valid=1 and acc_out equal to the final total (latency: one cycle after the last accept).
REQ-018 SHALL hold acc_out, acc_ovf and acc_valid stable in HOLD while acc_ready=0.
REQ-019 SHALL, in HOLD with acc_ready=1, return to ACCUM on the next edge with acc_valid=0, accumulator, counter and acc_ovf zeroed; no sum is accepted in that handshake cycle.
REQ-020 SHALL ignore acc_ready when acc_valid=0 and ignore sum_in when sum_valid=0.
REQ-021 SHALL, when clear=1 in any state, go to ACCUM on the next edge with accumulator, counter, acc_ovf and acc_valid zeroed; clear has priority over accept and over the output handshake.
REQ-022 SHALL support BURST_LEN=1 (every accepted sum produces a result).
REQ-023 SHALL size the sample counter to hold 0..BURST_LEN and never wrap past BURST_LEN.

Reset
REQ-024 SHALL, while reset=0, force state ACCUM, accumulator=0, counter=0, acc_out=0, acc_ovf=0, acc_valid=0, sum_ready=0, independent of clk.
REQ-025 SHALL assert reset mid-burst or in HOLD discarding all partial and pending results; sum_ready=1 from the first edge after reset release.

Configuration
REQ-026 SHALL, with macro SUM_SATURATE_EN defined, clamp the accumulator at 2^ACC_W-1 once an add overflows, with later adds in the burst leaving it at all-ones.
REQ-027 SHALL, without SUM_SATURATE_EN, let the accumulator wrap modulo 2^ACC_W; acc_ovf behaves identically in both builds.

Verification
REQ-028 SHALL cover: defaults, sums 1,2,3,4 back-to-back, acc_ready=1 -> acc_valid=1 one cycle after 4th accept, acc_out=10, acc_ovf=0.
REQ-029 SHALL cover: result pending, acc_ready=0 for 5 cycles with sum_valid=1 -> sum_ready=0, acc_out stable; acc_ready=1 -> acc_valid=0 next cycle, next burst starts at 0.
REQ-030 SHALL cover: BURST_LEN=16, sixteen sums of 17'h1FFFF -> acc_ovf=1; acc_out=20'hFFFFF with SUM_SATURATE_EN, 20'hFFFF0 without.
REQ-031 SHALL cover: two sums accepted then clear=1 with sum_valid=1 -> sum_ready=0 that cycle; following sums 5,5,5,5 -> acc_out=20.
REQ-032 SHALL cover: reset=0 asserted mid-burst and in HOLD -> all outputs 0 immediately; after release, sums 7,0,0,1 -> acc_out=8.
REQ-033 SHALL cover: BURST_LEN=1, sums 3 then 9 with acc_ready tied 1 -> two results 3 and 9, sum_ready low exactly one cycle after each accept.
